// File: rtl/flipflops_pkg.sv
// flipflops_pkg: shared state encoding and counter sizing for the serial link
package flipflops_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/dff_sync_clear.sv
// dff_sync_clear: D flip-flop with synchronous active-high clear and inverted output
module dff_sync_clear (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q,
    output logic qbar
);
    always_ff @(posedge clk) q <= clear ? 1'b0 : d;
    assign qbar = ~q;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out transmitter with first/last framing
module piso_serializer
    import flipflops_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             busy
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, state_d;
    logic [CW-1:0] count, count_d;
    logic [WIDTH-1:0] sr, sr_d, sr_shift, qbar_unused;
    logic hs, head, shifting, at_last;
    always_comb begin
        shifting   = state == ST_SHIFT;
        at_last    = count == LAST;
        load_ready = !shifting || at_last;
        hs         = load_valid && load_ready;
        head       = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        sr_shift   = MSB_FIRST ? sr << 1 : sr >> 1;
        state_d    = (hs || (shifting && !at_last)) ? ST_SHIFT : ST_IDLE;
        count_d    = (hs || !shifting || at_last) ? '0 : count + 1'b1;
        sr_d       = hs ? din : shifting ? sr_shift : sr;
    end
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
        end
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_sr
        dff_sync_clear u_ff (
            .clk  (clk),
            .clear(clear),
            .d    (sr_d[i]),
            .q    (sr[i]),
            .qbar (qbar_unused[i])
        );
    end
    assign sout       = shifting && head;
    assign sout_valid = shifting;
    assign sout_first = shifting && count == '0;
    assign sout_last  = shifting && at_last;
    assign busy       = shifting;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of MSB-first, LSB-first and single-bit serializer instances
module tb_piso_serializer;
    logic clk = 1'b0, clear = 1'b0;
    logic lv_m = 1'b0, lv_l = 1'b0, lv_w = 1'b0;
    logic [7:0] din_m = '0, din_l = '0;
    logic [0:0] din_w = '0;
    logic so_m, sv_m, sf_m, sl_m, bz_m, rd_m;
    logic so_l, sv_l, sf_l, sl_l, bz_l, rd_l;
    logic so_w, sv_w, sf_w, sl_w, bz_w, rd_w;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .clear(clear), .load_valid(lv_m), .load_ready(rd_m), .din(din_m),
        .sout(so_m), .sout_valid(sv_m), .sout_first(sf_m), .sout_last(sl_m), .busy(bz_m));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clear(clear), .load_valid(lv_l), .load_ready(rd_l), .din(din_l),
        .sout(so_l), .sout_valid(sv_l), .sout_first(sf_l), .sout_last(sl_l), .busy(bz_l));
    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
        .clk(clk), .clear(clear), .load_valid(lv_w), .load_ready(rd_w), .din(din_w),
        .sout(so_w), .sout_valid(sv_w), .sout_first(sf_w), .sout_last(sl_w), .busy(bz_w));
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        clear = 1'b1; lv_m = 1'b1; din_m = 8'hFF; lv_l = 1'b1; din_l = 8'hFF; lv_w = 1'b1; din_w = 1'b1;
        tick; tick;
        clear = 1'b0; lv_m = 1'b0; lv_l = 1'b0; lv_w = 1'b0;
        tests++;
        if ({so_m, sv_m, sf_m, sl_m, bz_m, rd_m} !== 6'b000001) begin
            fails++; $display("FAIL reset_msb got %b want 000001", {so_m, sv_m, sf_m, sl_m, bz_m, rd_m});
        end
        tests++;
        if ({sv_l, bz_l, rd_l, sv_w, bz_w, rd_w} !== 6'b001001) begin
            fails++; $display("FAIL reset_others got %b want 001001", {sv_l, bz_l, rd_l, sv_w, bz_w, rd_w});
        end
        tick;
        tests++;
        if ({so_m, sv_m, bz_m, rd_m} !== 4'b0001) begin
            fails++; $display("FAIL reset_idle got %b want 0001", {so_m, sv_m, bz_m, rd_m});
        end
    endtask
    task automatic test_msb_single;
        logic [7:0] w = 8'hA5;
        lv_m = 1'b1; din_m = w;
        tick;
        lv_m = 1'b0; din_m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({so_m, sv_m, sf_m, sl_m, bz_m, rd_m} !== {w[7-i], 1'b1, i == 0, i == 7, 1'b1, i == 7}) begin
                fails++;
                $display("FAIL msb_a5 bit %0d got %b want %b", i, {so_m, sv_m, sf_m, sl_m, bz_m, rd_m},
                         {w[7-i], 1'b1, i == 0, i == 7, 1'b1, i == 7});
            end
            tick;
        end
        tests++;
        if ({so_m, sv_m, sf_m, sl_m, bz_m, rd_m} !== 6'b000001) begin
            fails++; $display("FAIL msb_a5_idle got %b want 000001", {so_m, sv_m, sf_m, sl_m, bz_m, rd_m});
        end
    endtask
    task automatic test_lsb_single;
        logic [7:0] w = 8'h01;
        int nvalid = 0;
        lv_l = 1'b1; din_l = w;
        tick;
        lv_l = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nvalid += int'(sv_l);
            tests++;
            if ({so_l, sv_l, sf_l, sl_l} !== {i < 8 && w[i % 8], i < 8, i == 0, i == 7}) begin
                fails++;
                $display("FAIL lsb_01 cycle %0d got %b want %b", i, {so_l, sv_l, sf_l, sl_l},
                         {i < 8 && w[i % 8], i < 8, i == 0, i == 7});
            end
            tick;
        end
        tests++;
        if (nvalid != 8) begin
            fails++; $display("FAIL lsb_valid_count got %0d want 8", nvalid);
        end
    endtask
    task automatic test_back_to_back;
        logic [15:0] w = 16'hF00F;
        lv_m = 1'b1; din_m = 8'hF0;
        tick;
        din_m = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if ({so_m, sv_m, sf_m, sl_m} !== {w[15-i], 1'b1, i == 0 || i == 8, i == 7 || i == 15}) begin
                fails++;
                $display("FAIL b2b bit %0d got %b want %b", i, {so_m, sv_m, sf_m, sl_m},
                         {w[15-i], 1'b1, i == 0 || i == 8, i == 7 || i == 15});
            end
            if (i == 8) lv_m = 1'b0;
            tick;
        end
        tests++;
        if ({sv_m, bz_m, rd_m} !== 3'b001) begin
            fails++; $display("FAIL b2b_idle got %b want 001", {sv_m, bz_m, rd_m});
        end
    endtask
    task automatic test_abort;
        lv_m = 1'b1; din_m = 8'hFF;
        tick;
        lv_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({so_m, sv_m} !== 2'b11) begin
                fails++; $display("FAIL abort_pre bit %0d got %b want 11", i, {so_m, sv_m});
            end
            tick;
        end
        clear = 1'b1;
        tick;
        clear = 1'b0;
        tests++;
        if ({so_m, sv_m, sf_m, sl_m, bz_m, rd_m} !== 6'b000001) begin
            fails++; $display("FAIL abort_cleared got %b want 000001", {so_m, sv_m, sf_m, sl_m, bz_m, rd_m});
        end
        lv_m = 1'b1; din_m = 8'h80;
        tick;
        lv_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({so_m, sv_m, sf_m, sl_m} !== {i == 0, 1'b1, i == 0, i == 7}) begin
                fails++;
                $display("FAIL abort_reload bit %0d got %b want %b", i, {so_m, sv_m, sf_m, sl_m},
                         {i == 0, 1'b1, i == 0, i == 7});
            end
            tick;
        end
        tests++;
        if ({sv_m, bz_m} !== 2'b00) begin
            fails++; $display("FAIL abort_end got %b want 00", {sv_m, bz_m});
        end
    endtask
    task automatic test_width1;
        logic [2:0] v = 3'b101;
        lv_w = 1'b1; din_w = v[0];
        tick;
        for (int k = 0; k < 3; k++) begin
            lv_w = k < 2;
            din_w = (k < 2) ? v[k+1] : 1'b0;
            tests++;
            if ({so_w, sv_w, sf_w, sl_w, bz_w, rd_w} !== {v[k], 5'b11111}) begin
                fails++;
                $display("FAIL w1 bit %0d got %b want %b", k, {so_w, sv_w, sf_w, sl_w, bz_w, rd_w}, {v[k], 5'b11111});
            end
            tick;
        end
        tests++;
        if ({so_w, sv_w, sf_w, sl_w, bz_w, rd_w} !== 6'b000001) begin
            fails++; $display("FAIL w1_idle got %b want 000001", {so_w, sv_w, sf_w, sl_w, bz_w, rd_w});
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        tick;
        test_reset;
        test_msb_single;
        test_lsb_single;
        test_back_to_back;
        test_abort;
        test_width1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk.
- Provides framing strobes (first/last) so the team's serial-in/parallel-out receiver can reassemble words.
- Built as a chain of sync-clear D flip-flops plus a bit counter and a two-state controller.
- Sits on the transmit side of the serial link, driven by any word-producing stage.

Parameters:
- WIDTH, 8, word length in bits (>=1).
- MSB_FIRST, 1, 1 = shift din[WIDTH-1] first, 0 = shift din[0] first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset; sampled on rising clk.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  serializer can accept a word this cycle.
- din  input  WIDTH  parallel word; captured when load_valid && load_ready.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- sout_first  output  1  sout is bit 0 of a frame.
- sout_last  output  1  sout is bit WIDTH-1 of a frame.
- busy  output  1  frame in progress (state == SHIFT).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named clear.
- clear=1 at an edge forces state=IDLE, shift register=0, count=0.
  - After that edge: sout=0, sout_valid=0, sout_first=0, sout_last=0, busy=0, load_ready=1.
- clear has priority over a simultaneous load handshake; that word is dropped.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1; all serial outputs 0.
  - Handshake at an edge loads din into the shift register, sets count=0, and moves to SHIFT.
- SHIFT:
  - sout = head bit of the shift register (MSB or LSB per MSB_FIRST); sout_valid=1.
  - sout_first = (count==0); sout_last = (count==WIDTH-1).
  - Each edge: shift by one toward the head, fill with 0, count+1.
- Latency: word accepted at edge N; its first bit is visible in the cycle after edge N. Frame occupies exactly WIDTH consecutive cycles.
- load_ready in SHIFT is 1 only when count==WIDTH-1, which allows back-to-back frames.
  - Handshake on the last bit: reload din, count=0, stay in SHIFT. No idle gap; sout_first is asserted the cycle after sout_last.
  - No handshake on the last bit: go to IDLE.
- load_valid while load_ready=0 is ignored (producer must hold). din is don't-care without a handshake.
- WIDTH=1: every frame is one cycle; sout_first and sout_last are both high on that bit.
- clear mid-frame aborts the frame immediately; no remaining bits are emitted.
- count width is max(1, clog2(WIDTH)); count never exceeds WIDTH-1.
- All outputs are registered or decoded from registered state only. No combinational path from load_valid to sout. load_ready depends on state/count only.

Decomposition:
- Shared package (flipflops_pkg):
  - State encoding localparams: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Helper function for counter width, max(1, clog2(n)), reused by the matching receiver.
- One natural sub-module: dff_sync_clear (ports clk, clear, d, q, qbar), instantiated WIDTH times via generate for the shift register.
- Controller and counter stay in piso_serializer.

Test Plan:
- Reset: hold clear=1 for 2 edges with load_valid=1 and din=8'hFF -> after release, all serial outputs 0, busy=0, load_ready=1, nothing shifted.
- Single word, MSB_FIRST=1, din=8'hA5 -> sout over 8 cycles 1,0,1,0,0,1,0,1; sout_first on cycle 1, sout_last on cycle 8; then IDLE.
- MSB_FIRST=0, din=8'h01 -> sout 1,0,0,0,0,0,0,0; sout_valid high for exactly 8 cycles.
- Back-to-back: load_valid held high with 8'hF0 then 8'h0F -> 16 contiguous valid bits 11110000 00001111, sout_first at cycles 1 and 9, no gap.
- Abort: load 8'hFF, assert clear after bit 3 -> next cycle sout_valid=0, sout=0, busy=0; next load 8'h80 starts a clean frame.
- WIDTH=1 instance with alternating din 1,0,1 held valid -> sout 1,0,1 on consecutive cycles, first=last=1 each cycle.
